// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types for the run sequencer: FSM state and run status encodings.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package run_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESET  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } run_state_t;

  // Reported run outcome; the RS_ prefix keeps RS_TIMEOUT clear of the
  // TIMEOUT parameter of run_ctrl.
  typedef enum logic [1:0] {
    RS_OK      = 2'b00,
    RS_TIMEOUT = 2'b01,
    RS_ABORT   = 2'b10
  } run_status_t;

endpackage

`default_nettype wire

// File: rtl/run_cnt.sv
// ---------------------------------------------------------------------------
// run_cnt
// CW-bit up counter with synchronous clear, count enable and a saturation
// flag. The count sticks at all-ones and never wraps.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module run_cnt #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          sat
);

  assign sat = &count;

  // Clear has priority over enable; a saturated count holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !sat) begin
      count <= count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
// Run sequencer in front of the processor core. Holds the core in reset
// while idle, issues a REQ_CYCLES reset pulse on start, counts RUN cycles
// until core_done or abort, then reports status and cycle count.
// Optional watchdog: define RUN_CTRL_TIMEOUT_EN to end a run after TIMEOUT
// RUN cycles with status TIMEOUT.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned REQ_CYCLES = 2,
  parameter int unsigned CW         = 16,
  parameter int unsigned TIMEOUT    = 16'd50000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          core_done,
  output logic          core_req,
  output logic          busy,
  output logic          run_valid,
  output logic [1:0]    run_status,
  output logic [CW-1:0] cycle_count
);

  // Width of the RESET-length counter; at least one bit even for REQ_CYCLES=1.
  localparam int unsigned     RW       = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [RW-1:0]   RST_LAST = RW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT - 1);

`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  run_state_t    state;
  run_state_t    state_nxt;
  run_status_t   status_r;
  run_status_t   status_nxt;
  logic [RW-1:0] rcnt;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_sat;
  logic [CW-1:0] count;
  logic          to_hit;

  // Watchdog fires on the RUN cycle whose count already reads TIMEOUT-1.
  assign to_hit = TO_EN && (count == TO_LAST);

  run_cnt #(
    .CW(CW)
  ) u_run_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clr),
    .en      (cnt_en),
    .count   (count),
    .sat     (cnt_sat)
  );

  // Next-state, report status and counter control; abort > done > timeout.
  always_comb begin
    state_nxt  = state;
    status_nxt = status_r;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RESET;
        end
      end
      RESET: begin
        if (abort) begin
          state_nxt  = REPORT;
          status_nxt = RS_ABORT;
        end else if (rcnt == RST_LAST) begin
          state_nxt = RUN;
          cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt  = REPORT;
          status_nxt = RS_ABORT;
        end else if (core_done) begin
          state_nxt  = REPORT;
          status_nxt = RS_OK;
        end else if (to_hit) begin
          state_nxt  = REPORT;
          status_nxt = RS_TIMEOUT;
        end else begin
          cnt_en = !cnt_sat;
        end
      end
      REPORT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and RESET-length counter (restarts on every RESET entry).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == RESET) && (state_nxt == RESET)) begin
        rcnt <= rcnt + RW'(1);
      end else begin
        rcnt <= '0;
      end
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_req  <= 1'b1;
      busy      <= 1'b0;
      run_valid <= 1'b0;
      status_r  <= RS_OK;
    end else begin
      core_req  <= (state_nxt != RUN);
      busy      <= (state_nxt == RESET) || (state_nxt == RUN);
      run_valid <= (state_nxt == REPORT);
      status_r  <= status_nxt;
    end
  end

  assign run_status  = status_r;
  assign cycle_count = count;

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl
// Scoreboard bench for run_ctrl: stimulus pushes expected reports, monitors
// pop and compare on every run_valid pulse. A second CW=4 instance covers
// counter saturation. Honors RUN_CTRL_TIMEOUT_EN when defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_run_ctrl;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        core_done;
  logic        core_req;
  logic        busy;
  logic        run_valid;
  logic [1:0]  run_status;
  logic [15:0] cycle_count;

  logic        s_start;
  logic        s_abort;
  logic        s_done;
  logic        s_req;
  logic        s_busy;
  logic        s_valid;
  logic [1:0]  s_status;
  logic [3:0]  s_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t q_main[$];
  exp_t q_sat[$];

  always #5 clk = ~clk;

  run_ctrl #(.REQ_CYCLES(2), .CW(16), .TIMEOUT(1000)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .core_done   (core_done),
    .core_req    (core_req),
    .busy        (busy),
    .run_valid   (run_valid),
    .run_status  (run_status),
    .cycle_count (cycle_count)
  );

  run_ctrl #(.REQ_CYCLES(2), .CW(4), .TIMEOUT(16)) u_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (s_start),
    .abort       (s_abort),
    .core_done   (s_done),
    .core_req    (s_req),
    .busy        (s_busy),
    .run_valid   (s_valid),
    .run_status  (s_status),
    .cycle_count (s_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic [15:0] c);
    exp_t r;
    r.st  = s;
    r.cnt = c;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Accept a start from IDLE and step to RUN cycle 0, checking core_req timing.
  task automatic go_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
    chk("req_reset_cyc1", 32'(core_req), 1);
    tick(1);
    chk("req_reset_cyc2", 32'(core_req), 1);
    tick(1);
    chk("req_run_entry", 32'(core_req), 0);
    chk("busy_run", 32'(busy), 1);
  endtask

  // Main DUT monitor.
  always @(negedge clk) begin
    exp_t e;
    if (run_valid === 1'b1) begin
      if (q_main.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_report: status=%0d count=%0d, no report expected", run_status, cycle_count);
      end else begin
        e = q_main.pop_front();
        chk("report_status", 32'(run_status), 32'(e.st));
        chk("report_count", 32'(cycle_count), 32'(e.cnt));
        chk("report_core_req", 32'(core_req), 1);
        chk("report_busy", 32'(busy), 0);
      end
    end
  end

  // Saturation instance monitor.
  always @(negedge clk) begin
    exp_t e;
    if (s_valid === 1'b1) begin
      if (q_sat.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sat_report: status=%0d count=%0d, no report expected", s_status, s_count);
      end else begin
        e = q_sat.pop_front();
        chk("sat_status", 32'(s_status), 32'(e.st));
        chk("sat_count", 32'(s_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_ok;
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    core_done = 1'b0;
    s_start   = 1'b0;
    s_abort   = 1'b0;
    s_done    = 1'b0;
    tick(3);
    chk("rst_core_req", 32'(core_req), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_run_valid", 32'(run_valid), 0);
    chk("rst_status", 32'(run_status), 0);
    chk("rst_count", 32'(cycle_count), 0);
    reset_n = 1'b1;
    tick(2);

    // Normal run: done 450 cycles after core_req falls.
    q_main.push_back(mk(2'b00, 16'd450));
    go_run();
    tick(450);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    chk("normal_report_req", 32'(core_req), 1);
    tick(1);
    chk("normal_idle_valid", 32'(run_valid), 0);
    chk("normal_idle_busy", 32'(busy), 0);
    chk("normal_count_held", 32'(cycle_count), 450);

    // Abort at RUN cycle 100.
    q_main.push_back(mk(2'b10, 16'd100));
    go_run();
    tick(100);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_report_req", 32'(core_req), 1);
    tick(1);

    // Abort and done together: abort wins.
    q_main.push_back(mk(2'b10, 16'd10));
    go_run();
    tick(10);
    abort     = 1'b1;
    core_done = 1'b1;
    tick(1);
    abort     = 1'b0;
    core_done = 1'b0;
    tick(1);

    // Ignored inputs: done high in IDLE/RESET, start held through RUN/REPORT.
    core_done = 1'b1;
    tick(2);
    chk("done_in_idle_busy", 32'(busy), 0);
    start = 1'b1;
    tick(2);
    chk("done_in_reset_req", 32'(core_req), 1);
    tick(1);
    core_done = 1'b0;
    chk("done_in_reset_ignored", 32'(core_req), 0);
    q_main.push_back(mk(2'b00, 16'd5));
    tick(5);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    chk("hold_start_report_busy", 32'(busy), 0);
    tick(1);
    chk("hold_start_idle_busy", 32'(busy), 0);
    chk("hold_start_idle_req", 32'(core_req), 1);
    tick(1);
    chk("restart_from_idle", 32'(busy), 1);
    start = 1'b0;
    tick(2);
    chk("restart_run_req", 32'(core_req), 0);
    q_main.push_back(mk(2'b00, 16'd3));
    tick(3);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    tick(1);

`ifdef RUN_CTRL_TIMEOUT_EN
    // Watchdog: TIMEOUT=1000, done never rises.
    q_main.push_back(mk(2'b01, 16'd999));
    go_run();
    tick(999);
    chk("timeout_pre_busy", 32'(busy), 1);
    tick(1);
    tick(1);
`else
    // No watchdog: 5000 RUN cycles without a report, then abort.
    go_run();
    busy_ok = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk("no_timeout_busy", 32'(busy_ok), 1);
    q_main.push_back(mk(2'b10, 16'd5000));
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
`endif

    // Asynchronous reset at RUN cycle 37.
    go_run();
    tick(37);
    chk("run37_count", 32'(cycle_count), 37);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_core_req", 32'(core_req), 1);
    chk("async_busy", 32'(busy), 0);
    chk("async_valid", 32'(run_valid), 0);
    chk("async_status", 32'(run_status), 0);
    chk("async_count", 32'(cycle_count), 0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // Saturation: CW=4, done at RUN cycle 20.
`ifdef RUN_CTRL_TIMEOUT_EN
    q_sat.push_back(mk(2'b01, 16'd15));
`else
    q_sat.push_back(mk(2'b00, 16'd15));
`endif
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    tick(2);
    chk("sat_run_entry_req", 32'(s_req), 0);
    tick(20);
    s_done = 1'b1;
    tick(1);
    s_done = 1'b0;
    tick(5);

    chk("main_queue_empty", 32'(q_main.size()), 0);
    chk("sat_queue_empty", 32'(q_sat.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_ctrl.md
# run_ctrl

Run sequencer that sits directly upstream of the processor core and drives its `req` input. It holds the core in reset while idle. On a start request it issues a reset pulse of guaranteed length, then releases the core and counts execution cycles until the core raises `done`. It reports a cycle count and status, with an optional watchdog timeout.

## Interface

Parameters:
- `REQ_CYCLES`, 2: minimum cycles `core_req` is held high after an accepted start (≥1).
- `CW`, 16: cycle counter width.
- `TIMEOUT`, 16'd50000: watchdog limit in RUN cycles (used only with the macro enabled).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: run request; accepted only in IDLE.
- `abort`, in, 1: terminate the current run.
- `core_done`, in, 1: the core's `done` output.
- `core_req`, out, 1: drives the core's `req` (reset) input.
- `busy`, out, 1: high in RESET and RUN.
- `run_valid`, out, 1: one-cycle pulse in REPORT.
- `run_status`, out, 2: 00 OK, 01 TIMEOUT, 10 ABORT; held until the next report.
- `cycle_count`, out, CW: RUN cycles elapsed; held after REPORT.

## Operation

- **States:**
  - IDLE: `core_req`=1, `busy`=0.
  - RESET: `core_req`=1, `busy`=1.
  - RUN: `core_req`=0, `busy`=1.
  - REPORT: `core_req`=1, `busy`=0, `run_valid`=1.
- **IDLE → RESET** on `start`=1.
  - `start` in any other state is ignored and is not queued.
- **RESET:**
  - Internal counter runs 0..REQ_CYCLES-1.
  - Moves to RUN after exactly REQ_CYCLES cycles in RESET.
- **Entering RUN:**
  - `cycle_count` clears to 0.
  - Each RUN cycle with `core_done`=0 increments it.
  - Saturates at all-ones and never wraps.
- **RUN → REPORT, `run_status`=OK** on `core_done`=1 sampled in RUN.
  - `cycle_count` is not incremented on that cycle.
- **RUN or RESET → REPORT, `run_status`=ABORT** on `abort`=1.
  - `abort` in IDLE or REPORT is ignored.
- **REPORT → IDLE** unconditionally after one cycle.
- **Simultaneous events:**
  - `abort` and `core_done` in the same cycle: `abort` wins.
  - `core_done` and timeout in the same cycle: `core_done` wins (OK).
- **Glitch filtering:** `core_done` is only observed in RUN. A high value in other states is a don't-care, which covers the combinational `done` glitching while the PC is in reset.
- **Reset values:**
  - State = IDLE.
  - `core_req`=1, `busy`=0, `run_valid`=0.
  - `run_status`=00, `cycle_count`=0.
- **Reset mid-run:** asserting `reset_n` mid-run returns to reset values immediately, asynchronously. `core_req` rises without waiting for a clock.

## Timing

- `start` sampled at edge t:
  - `core_req` stays 1 and `busy`=1 from t+1.
  - `core_req` falls at t+REQ_CYCLES+1 (RUN entry).
- Run that starts at edge r and sees `core_done` at edge r+N:
  - `run_valid`=1 in cycle r+N+1.
  - `cycle_count`=N at that point.
  - `core_req`=1 again in the same cycle.
- Minimum start-to-start spacing: REQ_CYCLES+3 cycles (RESET + ≥1 RUN + REPORT + IDLE).
- All outputs are registered. `core_req` is a flop output with no combinational path from `start`.

## Configuration

- `RUN_CTRL_TIMEOUT_EN` defined:
  - In RUN, when `cycle_count` equals TIMEOUT-1 and `core_done`=0, the next state is REPORT with `run_status`=TIMEOUT.
  - `cycle_count` reads TIMEOUT-1.
- Not defined:
  - No watchdog; RUN lasts until `core_done` or `abort`.
  - `run_status` 01 is never produced.
  - The `TIMEOUT` parameter is unused.

## Structure

- Package `run_ctrl_pkg`:
  - State enum `run_state_t` (IDLE, RESET, RUN, REPORT).
  - Status enum `run_status_t` (OK=2'b00, TIMEOUT=2'b01, ABORT=2'b10).
- One sub-module, `run_cnt`:
  - Parameterised CW-bit counter with synchronous clear, enable, and saturation flag.
  - Used for the RUN cycle count. The RESET-length counter is a small local counter in `run_ctrl`.

## Test plan

- **Normal run:** REQ_CYCLES=2; stub core raises `core_done` 450 cycles after `core_req` falls; pulse `start`.
  - `core_req` is high exactly 2 cycles after accept.
  - `run_valid` pulses once with `run_status`=00 and `cycle_count`=450.
- **Abort:** `abort` pulsed at RUN cycle 100.
  - Next cycle is REPORT with `run_status`=10 and `cycle_count`=100.
  - `core_req`=1.
- **Timeout:** `RUN_CTRL_TIMEOUT_EN` defined, TIMEOUT=1000, `core_done` never rises.
  - REPORT with `run_status`=01 and `cycle_count`=999.
  - With the macro undefined, no report occurs within 5000 cycles and `busy` stays 1.
- **Ignored inputs:** `start` held high through RUN and REPORT, plus `core_done`=1 during IDLE and RESET.
  - Exactly one report per accepted start.
  - A second run begins only from IDLE.
- **Collision and reset:**
  - `abort` and `core_done` in the same cycle → `run_status`=10.
  - `reset_n` asserted at RUN cycle 37 → `core_req`=1 without a clock edge, and all outputs take reset values.
- **Saturation:** CW=4, no timeout, `core_done` at RUN cycle 20 → `cycle_count`=15.
